// File: rtl/joy_db15_pkg.sv
// rtl/joy_db15_pkg.sv - shared constants and helpers for the DB15 joystick responder
package joy_db15_pkg;

  localparam int NBITS_DEF    = 12;
  localparam int NPLAYERS_DEF = 2;

  // Button positions within one player's serial word (same mapping as the reader)
  localparam int JB_RIGHT = 0;
  localparam int JB_LEFT  = 1;
  localparam int JB_DOWN  = 2;
  localparam int JB_UP    = 3;
  localparam int JB_B1    = 4;
  localparam int JB_B2    = 5;
  localparam int JB_B3    = 6;
  localparam int JB_START = 7;
  localparam int JB_COIN  = 8;

  function automatic int frame_len(input int nbits, input int nplayers);
    return nbits * nplayers;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - multi-flop synchroniser with rising/falling edge pulses, presets to 1
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  // Lines idle high, so every flop comes out of reset at 1 to avoid a phantom edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain <= '1;
      prev  <= 1'b1;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      prev  <= chain[STAGES-1];
    end
  end

  assign q    = chain[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/joy_db15_responder.sv
// rtl/joy_db15_responder.sv - emulates the 74HC165 chain of a serial DB15 joystick adapter
module joy_db15_responder
  import joy_db15_pkg::*;
#(
  parameter int NBITS       = NBITS_DEF,
  parameter int NPLAYERS    = NPLAYERS_DEF,
  parameter int SYNC_STAGES = 2,
  localparam int TOTAL      = frame_len(NBITS, NPLAYERS),
  localparam int CW         = $clog2(TOTAL + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             joy_clk,
  input  logic             joy_load,
  output logic             joy_data,
  input  logic [NBITS-1:0] joystick1,
  input  logic [NBITS-1:0] joystick2,
  output logic             frame_done,
  output logic             overrun,
  output logic [CW-1:0]    bit_count
);

  logic clk_s, clk_rise, clk_fall;
  logic load_s, load_rise, load_fall;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_clk (
    .clk   (clk),
    .reset (reset),
    .d     (joy_clk),
    .q     (clk_s),
    .rise  (clk_rise),
    .fall  (clk_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_load (
    .clk   (clk),
    .reset (reset),
    .d     (joy_load),
    .q     (load_s),
    .rise  (load_rise),
    .fall  (load_fall)
  );

  logic unused_edges;
  assign unused_edges = &{1'b0, clk_s, clk_fall, load_rise, load_fall};

  logic [TOTAL-1:0] load_vec;
  logic [TOTAL-1:0] sreg;

  generate
    if (NPLAYERS >= 2) begin : g_two
      assign load_vec = TOTAL'({joystick2, joystick1});
    end else begin : g_one
      logic unused_j2;
      assign unused_j2 = &{1'b0, joystick2};
      assign load_vec  = TOTAL'(joystick1);
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sreg       <= '0;
      bit_count  <= '0;
      overrun    <= 1'b0;
      frame_done <= 1'b0;
      joy_data   <= 1'b1;
    end else begin
      frame_done <= 1'b0;
      joy_data   <= ~sreg[0];
      if (!load_s) begin
        // Transparent parallel load; any coincident clock edge is dropped
        sreg      <= load_vec;
        bit_count <= '0;
        overrun   <= 1'b0;
      end else if (clk_rise) begin
        // Zero shifted in reads as released (1) on the inverted wire
        sreg <= {1'b0, sreg[TOTAL-1:1]};
        if (bit_count < CW'(TOTAL)) begin
          bit_count <= bit_count + 1'b1;
        end else begin
          overrun <= 1'b1;
        end
        if (bit_count == CW'(TOTAL - 1)) begin
          frame_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_joy_db15_responder.sv
// tb/tb_joy_db15_responder.sv - scoreboard bench with a frame-level reader model
module tb_joy_db15_responder;

  localparam int NBITS = 12;
  localparam int TOTAL = 24;
  localparam int CW    = $clog2(TOTAL + 1);

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             joy_clk = 1'b0;
  logic             joy_load = 1'b1;
  logic             joy_data;
  logic [NBITS-1:0] joystick1 = '0;
  logic [NBITS-1:0] joystick2 = '0;
  logic             frame_done;
  logic             overrun;
  logic [CW-1:0]    bit_count;

  joy_db15_responder #(.NBITS(NBITS), .NPLAYERS(2), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .joy_clk    (joy_clk),
    .joy_load   (joy_load),
    .joy_data   (joy_data),
    .joystick1  (joystick1),
    .joystick2  (joystick2),
    .frame_done (frame_done),
    .overrun    (overrun),
    .bit_count  (bit_count)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the frame as the wire should present it, plus progress counters
  int model_bits[$];
  int model_idx  = 0;
  int model_over = 0;
  int exp_fd     = 0;
  int fd_count   = 0;
  int exp_q[$];
  int rx_q[$];
  bit mon_en = 1'b1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_load(input logic [NBITS-1:0] j1, input logic [NBITS-1:0] j2);
    model_bits.delete();
    for (int b = 0; b < NBITS; b++) model_bits.push_back(j1[b] ? 0 : 1);
    for (int b = 0; b < NBITS; b++) model_bits.push_back(j2[b] ? 0 : 1);
    model_idx  = 0;
    model_over = 0;
    rx_q.delete();
  endtask

  task automatic do_load(input logic [NBITS-1:0] j1, input logic [NBITS-1:0] j2);
    joystick1 = j1;
    joystick2 = j2;
    joy_load  = 1'b0;
    model_load(j1, j2);
    wait_clk(6);
    joy_load = 1'b1;
    wait_clk(6);
  endtask

  task automatic shift_edge();
    exp_q.push_back(model_idx < TOTAL ? model_bits[model_idx] : 1);
    if (model_idx == TOTAL - 1) exp_fd++;
    if (model_idx < TOTAL) model_idx++;
    else model_over = 1;
    joy_clk = 1'b1;
    wait_clk(8);
    joy_clk = 1'b0;
    wait_clk(8);
  endtask

  task automatic check_state(input string tag);
    chk({tag, " bit_count"}, int'(bit_count), model_idx);
    chk({tag, " overrun"}, int'(overrun), model_over);
    chk({tag, " frame_done count"}, fd_count, exp_fd);
  endtask

  // Monitor: the reader samples joy_data as it raises joy_clk
  always @(posedge joy_clk) begin
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        chk("unexpected sample", 1, 0);
      end else begin
        chk("wire bit", int'(joy_data), exp_q.pop_front());
        rx_q.push_back(int'(joy_data));
      end
    end
  end

  always @(negedge clk) if (frame_done) fd_count++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NBITS-1:0] r1, r2, a, b;
    wait_clk(4);
    reset = 1'b0;
    wait_clk(8);
    chk("reset joy_data", int'(joy_data), 1);
    check_state("reset");

    // Single pressed button in bit 0
    do_load(12'h001, 12'h000);
    for (int i = 0; i < TOTAL; i++) shift_edge();
    check_state("frame 001");
    chk("first rx bit", rx_q[0], 0);

    // Reader reconstruction of both players
    do_load(12'hA5A, 12'h3C3);
    for (int i = 0; i < TOTAL; i++) shift_edge();
    check_state("frame A5A");
    a = '0;
    b = '0;
    for (int i = 0; i < NBITS; i++) begin
      a[i] = (rx_q[i] == 0);
      b[i] = (rx_q[NBITS + i] == 0);
    end
    chk("reconstructed joystick1", int'(a), 12'hA5A);
    chk("reconstructed joystick2", int'(b), 12'h3C3);

    // Overrun past the end of the frame, cleared by the next load
    do_load(NBITS'($urandom), NBITS'($urandom));
    for (int i = 0; i < TOTAL + 3; i++) shift_edge();
    check_state("overrun");
    do_load(NBITS'($urandom), NBITS'($urandom));
    check_state("after reload");

    // Mid-frame abort
    for (int i = 0; i < 10; i++) shift_edge();
    check_state("ten shifts");
    do_load(12'hFFF, joystick2);
    check_state("abort reload");
    for (int i = 0; i < TOTAL; i++) shift_edge();
    check_state("post-abort frame");
    for (int i = 0; i < NBITS; i++) chk("abort frame zero", rx_q[i], 0);

    // Reset mid-frame with coincident load fall and clock edge
    do_load(NBITS'($urandom), NBITS'($urandom));
    for (int i = 0; i < 5; i++) shift_edge();
    mon_en   = 1'b0;
    r1       = NBITS'($urandom);
    r2       = NBITS'($urandom);
    joystick1 = r1;
    joystick2 = r2;
    reset    = 1'b1;
    joy_load = 1'b0;
    joy_clk  = 1'b1;
    #1;
    chk("async reset joy_data", int'(joy_data), 1);
    chk("async reset bit_count", int'(bit_count), 0);
    wait_clk(3);
    reset = 1'b0;
    model_load(r1, r2);
    wait_clk(8);
    chk("load wins bit_count", int'(bit_count), 0);
    joy_clk = 1'b0;
    wait_clk(8);
    chk("load held bit_count", int'(bit_count), 0);
    joy_load = 1'b1;
    wait_clk(6);
    mon_en = 1'b1;
    for (int i = 0; i < TOTAL; i++) shift_edge();
    check_state("post-reset frame");

    // Random frames; joystick inputs wiggle during shifting without effect
    for (int f = 0; f < 4; f++) begin
      int extra;
      extra = $urandom_range(0, 2);
      do_load(NBITS'($urandom), NBITS'($urandom));
      for (int i = 0; i < TOTAL + extra; i++) begin
        joystick1 = NBITS'($urandom);
        joystick2 = NBITS'($urandom);
        shift_edge();
      end
      check_state("random frame");
    end

    chk("scoreboard drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
